// File: rtl/obstacle_field.sv
// Scrolling pipe-obstacle field: N_OBS obstacles, LFSR gap heights, pixel hit, pass pulse and score.
// Define OBSTACLE_FIELD_ACCEL_EN to shorten the move period by 4096 clocks per pass.
module obstacle_field #(
  parameter int          N_OBS     = 3,
  parameter int          OBS_W     = 29,
  parameter int          GAP_H     = 120,
  parameter int          SCREEN_H  = 480,
  parameter int          SPAWN_X   = 670,
  parameter int          SPACING   = 230,
  parameter int          TIME_MAX  = 4000000,
  parameter int          H_MIN     = 50,
  parameter int          H_MAX     = 230,
  parameter int          PLAYER_X  = 100,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 video_on,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic [25:0]          speed_offset,
  input  logic [9:0]           seed_in,
  output logic                 obstacle_on,
  output logic [10*N_OBS-1:0]  obs_x,
  output logic [10*N_OBS-1:0]  gap_top,
  output logic                 pass_pulse,
  output logic [9:0]           score
);

  localparam int          RESPAWN_X = N_OBS * SPACING;
  localparam int          H_RANGE   = H_MAX - H_MIN + 1;
  localparam int          H_MID     = (H_MIN + H_MAX) / 2;
  localparam logic [27:0] TM        = 28'(TIME_MAX);

  if (RESPAWN_X > 1023) begin : g_respawn_range
    $error("obstacle_field: N_OBS*SPACING exceeds the 10-bit column range");
  end

  function automatic logic [9:0] rotl_low10(input logic [15:0] v, input int s);
    logic [9:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) r[k] = v[(k - s + 16) % 16];
    return r;
  endfunction

  logic [15:0]      lfsr;
  logic [25:0]      timer;
  logic [25:0]      thr;
  logic [27:0]      sub;
  logic             tick;
  logic             pass_hit;
  logic [N_OBS-1:0] hit;
  logic [N_OBS-1:0] at_player;

`ifdef OBSTACLE_FIELD_ACCEL_EN
  localparam logic [26:0] ACC_MAX = 27'(TIME_MAX / 2);
  logic [25:0] accel;
  logic [26:0] accel_sum;

  assign accel_sum = {1'b0, accel} + 27'd4096;
  assign sub       = {2'b0, speed_offset} + {2'b0, accel};

  always_ff @(posedge clk) begin
    if (reset)
      accel <= '0;
    else if (pass_pulse)
      accel <= (accel_sum >= ACC_MAX) ? ACC_MAX[25:0] : accel_sum[25:0];
  end
`else
  assign sub = {2'b0, speed_offset};
`endif

  // Period floor of 1 keeps the timer from stalling when the offset overshoots.
  assign thr      = (sub >= TM) ? 26'd1 : 26'(TM - sub);
  assign tick     = run && (timer >= thr);
  assign pass_hit = tick && (|at_player);

  for (genvar i = 0; i < N_OBS; i++) begin : g_obs
    logic [9:0]        obs_q;
    logic [9:0]        gap_q;
    logic [9:0]        mix;
    logic [9:0]        gap_new;
    logic signed [10:0] left;
    logic              col_in;
    logic              upper;
    logic              lower;

    // Each obstacle sees a different rotation so simultaneous respawns differ.
    assign mix     = rotl_low10(lfsr, i % 16) ^ seed_in;
    assign gap_new = 10'(H_MIN) + (mix % 10'(H_RANGE));

    assign left   = $signed({1'b0, obs_q}) - $signed(11'(OBS_W - 1));
    assign col_in = ($signed({1'b0, x}) >= left) && (x <= obs_q);
    assign upper  = y < gap_q;
    assign lower  = ({1'b0, y} >= ({1'b0, gap_q} + 11'(GAP_H))) && (y <= 10'(SCREEN_H - 1));

    assign hit[i]       = col_in && (upper || lower);
    assign at_player[i] = obs_q == 10'(PLAYER_X);

    assign obs_x[10*i +: 10]   = obs_q;
    assign gap_top[10*i +: 10] = gap_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        obs_q <= 10'(SPAWN_X + i * SPACING);
        gap_q <= 10'(H_MID);
      end else if (tick) begin
        if (obs_q == 10'd0) begin
          obs_q <= 10'(RESPAWN_X);
          gap_q <= gap_new;
        end else begin
          obs_q <= obs_q - 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= LFSR_SEED;
      timer       <= '0;
      obstacle_on <= 1'b0;
      pass_pulse  <= 1'b0;
      score       <= '0;
    end else begin
      if (lfsr == 16'd0)
        lfsr <= LFSR_SEED;
      else
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      if (tick)
        timer <= '0;
      else if (run)
        timer <= timer + 26'd1;

      obstacle_on <= video_on && (|hit);
      pass_pulse  <= pass_hit;
      if (pass_hit && (score != 10'd999))
        score <= score + 10'd1;
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field: one default-timed instance and one tiny fast-cycling instance.
module tb_obstacle_field;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        run, run2;
  logic        video_on;
  logic [9:0]  x, y;
  logic [25:0] speed_offset;
  logic [9:0]  seed_in, seed2;

  logic        obstacle_on, obstacle_on2;
  logic [29:0] obs_x, gap_top, obs_x2, gap_top2;
  logic        pass_pulse, pass_pulse2;
  logic [9:0]  score, score2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  obstacle_field #(.SPACING(100)) dut (
    .clk(clk), .reset(reset), .run(run), .video_on(video_on), .x(x), .y(y),
    .speed_offset(speed_offset), .seed_in(seed_in), .obstacle_on(obstacle_on),
    .obs_x(obs_x), .gap_top(gap_top), .pass_pulse(pass_pulse), .score(score)
  );

  // Respawn column 9, player column 5, one move every 2 clocks.
  obstacle_field #(.SPAWN_X(2), .SPACING(3), .PLAYER_X(5), .TIME_MAX(1)) dut2 (
    .clk(clk), .reset(reset2), .run(run2), .video_on(video_on), .x(x), .y(y),
    .speed_offset(26'd0), .seed_in(seed2), .obstacle_on(obstacle_on2),
    .obs_x(obs_x2), .gap_top(gap_top2), .pass_pulse(pass_pulse2), .score(score2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_obs0(input int target, input int budget);
    int n = 0;
    while (obs_x[9:0] != 10'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_x_%0d", target), obs_x[9:0], target);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_obs0"}, obs_x[9:0], 670);
    check({tag, "_obs1"}, obs_x[19:10], 770);
    check({tag, "_obs2"}, obs_x[29:20], 870);
    check({tag, "_gap0"}, gap_top[9:0], 140);
    check({tag, "_gap1"}, gap_top[19:10], 140);
    check({tag, "_gap2"}, gap_top[29:20], 140);
    check({tag, "_score"}, score, 0);
    check({tag, "_pass"}, pass_pulse, 0);
    check({tag, "_on"}, obstacle_on, 0);
  endtask

  initial begin
    logic [9:0] prev [3];
    logic [9:0] cur;
    int respawns;

    reset = 1; reset2 = 1; run = 0; run2 = 0; video_on = 0;
    x = 0; y = 0; speed_offset = 0; seed_in = 0; seed2 = 0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");

    // thr = 10: first move after 11 clocks
    reset = 0; speed_offset = 26'd3999990; run = 1;
    repeat (10) @(negedge clk);
    check("tick_not_yet", obs_x[9:0], 670);
    @(negedge clk);
    check("tick_first", obs_x[9:0], 669);
    repeat (11) @(negedge clk);
    check("tick_second", obs_x[9:0], 668);
    check("tick_second_obs1", obs_x[19:10], 768);
    run = 0;
    repeat (50) @(negedge clk);
    check("frozen_obs0", obs_x[9:0], 668);
    check("frozen_obs2", obs_x[29:20], 868);

    // offset equal to / above TIME_MAX saturates to a 2-clock period
    speed_offset = 26'd4000000; run = 1;
    @(negedge clk);
    check("sat_eq_wait", obs_x[9:0], 668);
    @(negedge clk);
    check("sat_eq_move", obs_x[9:0], 667);
    speed_offset = 26'h3FFFFFF;
    @(negedge clk);
    check("sat_gt_wait", obs_x[9:0], 667);
    @(negedge clk);
    check("sat_gt_move", obs_x[9:0], 666);

    wait_obs0(300, 1000);
    run = 0;
    check("gap_before_pixels", gap_top[9:0], 140);
    video_on = 1;
    x = 10'd272; y = 10'd139; @(negedge clk);
    check("pix_left_edge_upper", obstacle_on, 1);
    x = 10'd271; y = 10'd139; @(negedge clk);
    check("pix_left_outside", obstacle_on, 0);
    x = 10'd300; y = 10'd260; @(negedge clk);
    check("pix_lower_top", obstacle_on, 1);
    x = 10'd300; y = 10'd259; @(negedge clk);
    check("pix_gap_bottom", obstacle_on, 0);
    x = 10'd300; y = 10'd479; @(negedge clk);
    check("pix_last_line", obstacle_on, 1);
    x = 10'd301; y = 10'd139; @(negedge clk);
    check("pix_right_outside", obstacle_on, 0);
    x = 10'd300; y = 10'd260; video_on = 0; @(negedge clk);
    check("pix_video_off", obstacle_on, 0);

    run = 1;
    wait_obs0(100, 1000);
    check("pre_pass_score", score, 0);
    check("pre_pass_pulse", pass_pulse, 0);
    wait_obs0(99, 4);
    check("pass_pulse", pass_pulse, 1);
    check("pass_score", score, 1);
    @(negedge clk);
    check("pass_pulse_single", pass_pulse, 0);
    check("pass_score_hold", score, 1);

    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_state("reset_after_pass");

    // reset landing on the very edge of a pass tick must win
    reset = 0;
    wait_obs0(100, 1500);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("reset_on_pass_pulse", pass_pulse, 0);
    check("reset_on_pass_score", score, 0);
    check("reset_on_pass_obs0", obs_x[9:0], 670);
    @(negedge clk);
    check("reset_on_pass_late", pass_pulse, 0);

    reset = 0; seed_in = 10'd613;
    wait_obs0(0, 2000);
    repeat (2) @(negedge clk);
    check("respawn_x", obs_x[9:0], 300);
    check("respawn_neighbour", obs_x[19:10], 99);
    check("respawn_gap_range", (gap_top[9:0] >= 10'd50) && (gap_top[9:0] <= 10'd230), 1);

    // fast instance: 3500 moves, 1050 respawns, 1050 passes (score saturates)
    reset2 = 0; run2 = 1; respawns = 0;
    for (int k = 0; k < 3; k++) prev[k] = obs_x2[10*k +: 10];
    for (int c = 0; c < 7000; c++) begin
      @(negedge clk);
      seed2 = 10'(c * 37);
      if (c == 1) begin
        check("fast_first_pass", pass_pulse2, 1);
        check("fast_first_score", score2, 1);
      end
      for (int k = 0; k < 3; k++) begin
        cur = obs_x2[10*k +: 10];
        if (prev[k] == 10'd0 && cur == 10'd9) begin
          respawns++;
          check($sformatf("fast_gap_range_%0d", k),
                (gap_top2[10*k +: 10] >= 10'd50) && (gap_top2[10*k +: 10] <= 10'd230), 1);
        end
        prev[k] = cur;
      end
    end
    check("fast_respawn_count", respawns, 1050);
    check("score_saturated", score2, 999);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
